uart_loader: RTL and testbench
==============================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, gives clk cycles per UART bit (100 MHz / 115200).
REQ-002 Parameter IMG_WORDS, default 16384, gives the number of 32-bit words in one program image.
REQ-003 Port clk, input, 1, single clock; all state SHALL be on the rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port rx, input, 1, UART serial line (idle high), asynchronous to clk.
REQ-006 Port uart_data, output, 32, assembled word to write to memory.
REQ-007 Port uart_addr, output, 32, byte address of uart_data.
REQ-008 Port uart_wen, output, 1, one-cycle write strobe qualifying uart_data and uart_addr.
REQ-009 Port uart_done, output, 1, image fully loaded; CPU released from reset while high.
REQ-010 Port uart_err, output, 1, sticky framing-error flag.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; all rx timing below is relative to the synchronized signal.
REQ-012 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE->START on a synchronized rx low sample while uart_done=0; the bit-timer resets to 0.
REQ-014 START: at timer = CLKS_PER_BIT/2-1, rx low -> DATA with timer and bit index cleared; rx high -> IDLE (glitch, no byte).
REQ-015 DATA: sample rx every CLKS_PER_BIT cycles; 8 bits LSB first into a shift register; after bit 7 -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; rx high -> byte accepted; rx low -> byte discarded and uart_err set; both -> IDLE.
REQ-017 Accepted bytes SHALL be packed little-endian: byte k of a word (k = 0..3) goes to bits [8k+7:8k].
REQ-018 On acceptance of byte 3: uart_data = packed word, uart_addr = 4 x word index, uart_wen = 1 for exactly the next cycle; byte counter wraps to 0.
REQ-019 uart_data and uart_addr SHALL hold their values until the next write strobe.
REQ-020 Word index SHALL increment by 1 after each strobe; addresses are 0, 4, 8, ... , 4*(IMG_WORDS-1).
REQ-021 uart_done SHALL rise in the same cycle as the strobe of word IMG_WORDS-1 is deasserted, i.e. one cycle after that strobe, and stay high until rst.
REQ-022 While uart_done=1, rx SHALL be ignored (FSM held in IDLE, no strobes, no error updates).
REQ-023 A discarded byte (framing error) SHALL NOT advance the byte counter; the next good byte fills the same position.
REQ-024 uart_err SHALL remain set once set until rst; loading continues regardless.
REQ-025 At most one uart_wen pulse SHALL occur per 4 accepted bytes; uart_wen and uart_done are never both high.

Reset
REQ-026 rst=1 SHALL immediately force: FSM IDLE, timer/bit/byte/word counters 0, uart_data 0, uart_addr 0, uart_wen 0, uart_done 0, uart_err 0.
REQ-027 rst asserted mid-byte or mid-word SHALL discard the partial byte/word; after release, loading restarts at address 0.
REQ-028 Synchronizer flops SHALL reset to 1 (idle line) so release of rst creates no false start.

Verification (CLKS_PER_BIT=16, IMG_WORDS=2)
REQ-029 Send bytes 78 56 34 12 -> one uart_wen pulse with uart_data=0x12345678, uart_addr=0x0; uart_done=0.
REQ-030 Then send EF BE AD DE -> uart_wen with uart_data=0xDEADBEEF, uart_addr=0x4; uart_done=1 the cycle after; further bytes give no strobe.
REQ-031 Send byte 0xAA with stop bit low, then 78 56 34 12 -> uart_err=1; one strobe with data=0x12345678, addr=0x0.
REQ-032 rx low pulse of 4 cycles from idle -> no byte accepted, no strobe, uart_err=0.
REQ-033 Assert rst after bytes 78 56 -> all outputs 0; then 11 22 33 44 -> strobe data=0x44332211, addr=0x0.
REQ-034 Back-to-back bytes with no idle gap between stop bit and next start bit -> all bytes received correctly.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: receives a little-endian program image over UART and streams
// 32-bit words to memory, then releases the CPU via uart_done.
module uart_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int IMG_WORDS    = 16384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [31:0] uart_data,
   output logic [31:0] uart_addr,
   output logic        uart_wen,
   output logic        uart_done,
   output logic        uart_err
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0] LAST_ADDR = 32'(4 * (IMG_WORDS - 1));

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q;
   logic [1:0]    sync_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    bit_q;
   logic [1:0]    byte_q;
   logic [7:0]    shift_q;
   logic [23:0]   word_q;
   logic [29:0]   idx_q;
   logic [31:0]   data_q;
   logic [31:0]   addr_q;
   logic          wen_q;
   logic          done_q;
   logic          err_q;
   logic          rx_s;

   assign rx_s      = sync_q[1];
   assign uart_data = data_q;
   assign uart_addr = addr_q;
   assign uart_wen  = wen_q;
   assign uart_done = done_q;
   assign uart_err  = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         word_q  <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rx};
         wen_q  <= 1'b0;
         if (wen_q && addr_q == LAST_ADDR) done_q <= 1'b1;
         // once loaded the receiver is parked so a stray start bit cannot slip in
         if (done_q) state_q <= IDLE;
         else begin
            case (state_q)
               IDLE: if (!rx_s) begin
                  state_q <= START;
                  timer_q <= '0;
               end
               START: if (timer_q == HALF) begin
                  timer_q <= '0;
                  bit_q   <= '0;
                  state_q <= rx_s ? IDLE : DATA;
               end else timer_q <= timer_q + 1'b1;
               DATA: if (timer_q == FULL) begin
                  timer_q <= '0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end else timer_q <= timer_q + 1'b1;
               STOP: if (timer_q == FULL) begin
                  timer_q <= '0;
                  state_q <= IDLE;
                  // bytes enter word_q from the top so byte 0 ends up in [7:0]
                  if (!rx_s) err_q <= 1'b1;
                  else if (byte_q == 2'd3) begin
                     data_q <= {shift_q, word_q};
                     addr_q <= {idx_q, 2'b00};
                     wen_q  <= 1'b1;
                     idx_q  <= idx_q + 1'b1;
                     byte_q <= '0;
                  end else begin
                     word_q <= {shift_q, word_q[23:8]};
                     byte_q <= byte_q + 1'b1;
                  end
               end else timer_q <= timer_q + 1'b1;
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized UART image loads scored against a byte-level model.
module tb_uart_loader;
   localparam int CPB = 16;
   localparam int IW  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [31:0] uart_data, uart_addr;
   logic        uart_wen, uart_done, uart_err;

   typedef struct {
      logic [31:0] d;
      logic [31:0] a;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mb[$];
   int         m_words = 0;
   bit         m_err   = 0;
   bit         pend_last = 0;
   int         total  = 0;
   int         passed = 0;

   uart_loader #(.CLKS_PER_BIT(CPB), .IMG_WORDS(IW)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .uart_data(uart_data), .uart_addr(uart_addr),
      .uart_wen(uart_wen), .uart_done(uart_done), .uart_err(uart_err)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // model: good bytes collect in fours into a word at the next address until the image is full
   task automatic model_byte(logic [7:0] b, bit good);
      if (m_words >= IW) return;
      if (!good) begin
         m_err = 1;
         return;
      end
      mb.push_back(b);
      if (mb.size() == 4) begin
         exp_q.push_back('{d: {mb[3], mb[2], mb[1], mb[0]}, a: 32'(4 * m_words)});
         mb.delete();
         m_words++;
      end
   endtask

   task automatic send_byte(logic [7:0] b, bit good, int gap);
      model_byte(b, good);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = good;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      #1;
      check("rst_data", uart_data, 0);
      check("rst_addr", uart_addr, 0);
      check("rst_wen", uart_wen, 0);
      check("rst_done", uart_done, 0);
      check("rst_err", uart_err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("strobes_pending_at_reset", exp_q.size(), 0);
      exp_q.delete();
      mb.delete();
      m_words   = 0;
      m_err     = 0;
      pend_last = 0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (pend_last) begin
         check("done_after_last", uart_done, 1);
         pend_last = 0;
      end
      if (uart_wen) begin
         check("wen_done_exclusive", uart_done, 0);
         if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("data", uart_data, e.d);
            check("addr", uart_addr, e.a);
            if (e.a == 32'(4 * (IW - 1))) pend_last = 1;
         end
      end
   end

   initial begin
      logic [7:0] w0[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      logic [7:0] w1[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      logic [7:0] w2[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_err", uart_err, 0);
      check("glitch_done", uart_done, 0);
      send_byte(8'hAA, 0, 24);
      foreach (w0[i]) send_byte(w0[i], 1, 2);
      repeat (30) @(negedge clk);
      check("framing_err", uart_err, 1);
      check("one_word_done", uart_done, 0);
      check("framing_drain", exp_q.size(), 0);
      do_reset();
      send_byte(8'h78, 1, 2);
      send_byte(8'h56, 1, 2);
      do_reset();
      foreach (w2[i]) send_byte(w2[i], 1, 2);
      repeat (30) @(negedge clk);
      check("restart_drain", exp_q.size(), 0);
      check("restart_done", uart_done, 0);
      do_reset();
      foreach (w0[i]) send_byte(w0[i], 1, 0);
      repeat (20) @(negedge clk);
      check("b2b_word0_done", uart_done, 0);
      foreach (w1[i]) send_byte(w1[i], 1, 0);
      repeat (20) @(negedge clk);
      check("b2b_done", uart_done, 1);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1, 0);
      repeat (30) @(negedge clk);
      check("after_done_done", uart_done, 1);
      check("after_done_err", uart_err, 0);
      check("b2b_drain", exp_q.size(), 0);
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < 40 && m_words < IW; i++) begin
            bit good;
            good = ($urandom_range(0, 4) != 0);
            send_byte(8'($urandom), good, good ? $urandom_range(0, 3) : 24);
         end
         send_byte(8'($urandom), 1, 2);
         send_byte(8'($urandom), 0, 24);
         repeat (40) @(negedge clk);
         check("rand_err", uart_err, 32'(m_err));
         check("rand_done", uart_done, 32'(m_words == IW));
         check("rand_drain", exp_q.size(), 0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
